// File: rtl/dma_arb_if.sv
// Bus-hold handshake and grant bundle between the DMA channel arbiter and
// the transfer-timing FSM / CPU hold logic.
//   hrq         hold request to the CPU
//   hlda        hold acknowledge from the CPU
//   serviceDone one-cycle pulse: the granted channel's service is complete
//   validDack   one-hot active-high grant (VALID_DACKn)
//   dack        DACK pins, polarity already applied
//   grantValid  OR of validDack
//   grantCh     encoded granted channel (meaningful only when grantValid)
//   topCh       current highest-priority channel
interface dma_arb_if;
  logic       hrq;
  logic       hlda;
  logic       serviceDone;
  logic [3:0] validDack;
  logic [3:0] dack;
  logic       grantValid;
  logic [1:0] grantCh;
  logic [1:0] topCh;

  // Arbiter side
  modport master (
    output hrq, validDack, dack, grantValid, grantCh, topCh,
    input  hlda, serviceDone
  );

  // FSM / CPU side
  modport slave (
    input  hrq, validDack, dack, grantValid, grantCh, topCh,
    output hlda, serviceDone
  );
endinterface

// File: rtl/dma_priority_arbiter.sv
// 8237A-style DMA channel request/priority stage. Synchronises DREQ, applies
// polarity, mask and fixed/rotating priority, runs the HRQ/HLDA hold
// handshake and holds a one-hot grant until the timing FSM reports done.
// Ports:
//   CLK, RESET        clock, synchronous active-low reset
//   dreq              raw DREQ3..0 pins
//   dreqActiveLow     1 = DREQ pins active-low
//   dackActiveHigh    1 = DACK pins active-high
//   rotatingPriority  1 = rotating priority, 0 = fixed (ch0 highest)
//   ctrlDisable       1 = no new requests accepted
//   mask              1 = hardware DREQ ignored
//   softReq           software request bits (not masked)
//   bus               handshake / grant bundle (dma_arb_if.master)
module dma_priority_arbiter (
  input  logic             CLK,
  input  logic             RESET,
  input  logic [3:0]       dreq,
  input  logic             dreqActiveLow,
  input  logic             dackActiveHigh,
  input  logic             rotatingPriority,
  input  logic             ctrlDisable,
  input  logic [3:0]       mask,
  input  logic [3:0]       softReq,
  dma_arb_if.master        bus
);

  localparam int unsigned NUM_CH = 4;
  localparam int unsigned CH_W   = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_REQ   = 2'd1,
    ST_GRANT = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [NUM_CH-1:0]   reqSync_q, reqSync_d;
  logic                hrq_q, hrq_d;
  logic [NUM_CH-1:0]   validDack_q, validDack_d;
  logic                grantValid_q, grantValid_d;
  logic [CH_W-1:0]     grantCh_q, grantCh_d;
  logic [CH_W-1:0]     topCh_q, topCh_d;

  logic [NUM_CH-1:0]   pending;
  logic [CH_W-1:0]     top_eff;
  logic [CH_W-1:0]     sel_ch;
  logic                sel_found;
  logic [CH_W-1:0]     idx;

  // Hardware requests are masked; software requests bypass the mask
  assign reqSync_d = dreq ^ {NUM_CH{dreqActiveLow}};
  assign pending   = (reqSync_q & ~mask) | softReq;

  // Fixed mode always searches from ch0, even in the cycle before topCh
  // itself has been forced back to 0
  assign top_eff = rotatingPriority ? topCh_q : '0;

  // Highest-priority pending channel, searching topCh, topCh+1, ... mod 4
  always_comb begin
    sel_ch    = '0;
    sel_found = 1'b0;
    idx       = '0;
    for (int unsigned i = 0; i < NUM_CH; i++) begin
      idx = top_eff + CH_W'(i);
      if (!sel_found && pending[idx]) begin
        sel_ch    = idx;
        sel_found = 1'b1;
      end
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    hrq_d        = hrq_q;
    validDack_d  = validDack_q;
    grantValid_d = grantValid_q;
    grantCh_d    = grantCh_q;
    topCh_d      = topCh_q;

    unique case (state_q)
      ST_IDLE: begin
        hrq_d        = 1'b0;
        validDack_d  = '0;
        grantValid_d = 1'b0;
        if ((|pending) && !ctrlDisable) begin
          state_d = ST_REQ;
          hrq_d   = 1'b1;
        end
      end

      ST_REQ: begin
        if (ctrlDisable || !(|pending)) begin
          state_d = ST_IDLE;
          hrq_d   = 1'b0;
        end else if (bus.hlda) begin
          state_d      = ST_GRANT;
          validDack_d  = NUM_CH'(1) << sel_ch;
          grantValid_d = 1'b1;
          grantCh_d    = sel_ch;
        end
      end

      ST_GRANT: begin
        // serviceDone wins over a simultaneous hlda drop
        if (bus.serviceDone || !bus.hlda) begin
          state_d      = ST_IDLE;
          hrq_d        = 1'b0;
          validDack_d  = '0;
          grantValid_d = 1'b0;
          grantCh_d    = '0;
          if (bus.serviceDone && rotatingPriority) begin
            topCh_d = grantCh_q + CH_W'(1);
          end
        end
      end

      default: begin
        state_d      = ST_IDLE;
        hrq_d        = 1'b0;
        validDack_d  = '0;
        grantValid_d = 1'b0;
        grantCh_d    = '0;
      end
    endcase

    if (!rotatingPriority) begin
      topCh_d = '0;
    end
  end

  // State and output registers, synchronous active-low reset
  always_ff @(posedge CLK) begin
    if (!RESET) begin
      state_q      <= ST_IDLE;
      reqSync_q    <= '0;
      hrq_q        <= 1'b0;
      validDack_q  <= '0;
      grantValid_q <= 1'b0;
      grantCh_q    <= '0;
      topCh_q      <= '0;
    end else begin
      state_q      <= state_d;
      reqSync_q    <= reqSync_d;
      hrq_q        <= hrq_d;
      validDack_q  <= validDack_d;
      grantValid_q <= grantValid_d;
      grantCh_q    <= grantCh_d;
      topCh_q      <= topCh_d;
    end
  end

  assign bus.hrq        = hrq_q;
  assign bus.validDack  = validDack_q;
  assign bus.grantValid = grantValid_q;
  assign bus.grantCh    = grantCh_q;
  assign bus.topCh      = topCh_q;
  // Pin polarity applied after the grant register
  assign bus.dack       = dackActiveHigh ? validDack_q : ~validDack_q;

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Directed self-checking bench for dma_priority_arbiter.
module tb_dma_priority_arbiter;

  logic       CLK;
  logic       RESET;
  logic [3:0] dreq;
  logic       dreqActiveLow;
  logic       dackActiveHigh;
  logic       rotatingPriority;
  logic       ctrlDisable;
  logic [3:0] mask;
  logic [3:0] softReq;

  int checks;
  int errors;

  dma_arb_if bus ();

  dma_priority_arbiter dut (
    .CLK              (CLK),
    .RESET            (RESET),
    .dreq             (dreq),
    .dreqActiveLow    (dreqActiveLow),
    .dackActiveHigh   (dackActiveHigh),
    .rotatingPriority (rotatingPriority),
    .ctrlDisable      (ctrlDisable),
    .mask             (mask),
    .softReq          (softReq),
    .bus              (bus)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // One rising edge, then settle away from it
  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  // Bounded wait for a grant, then check the granted channel
  task automatic wait_grant(input string tag, input int ch);
    for (int i = 0; i < 10; i++) begin
      if (bus.grantValid) break;
      tick();
    end
    check({tag, "_gv"}, 32'(bus.grantValid), 32'd1);
    check({tag, "_vdack"}, 32'(bus.validDack), 32'(4'b0001 << ch));
    check({tag, "_ch"}, 32'(bus.grantCh), 32'(ch));
  endtask

  // Remove all requests and return to IDLE
  task automatic drain();
    dreq           = 4'b0000;
    softReq        = 4'b0000;
    bus.hlda       = 1'b0;
    bus.serviceDone = 1'b0;
    repeat (3) tick();
    check("drain_hrq", 32'(bus.hrq), 32'd0);
  endtask

  initial begin
    checks           = 0;
    errors           = 0;
    RESET            = 1'b0;
    dreq             = 4'b0000;
    dreqActiveLow    = 1'b0;
    dackActiveHigh   = 1'b0;
    rotatingPriority = 1'b0;
    ctrlDisable      = 1'b0;
    mask             = 4'b0000;
    softReq          = 4'b0000;
    bus.hlda         = 1'b0;
    bus.serviceDone  = 1'b0;
    #1;
    repeat (2) tick();

    // Reset values
    check("rst_hrq",   32'(bus.hrq),        32'd0);
    check("rst_vdack", 32'(bus.validDack),  32'd0);
    check("rst_gv",    32'(bus.grantValid), 32'd0);
    check("rst_ch",    32'(bus.grantCh),    32'd0);
    check("rst_top",   32'(bus.topCh),      32'd0);
    check("rst_dack",  32'(bus.dack),       32'hF);
    RESET = 1'b1;
    tick();

    // Basic handshake: two-edge DREQ latency, grant after hlda, release
    dreq = 4'b0100;
    tick();
    check("basic_hrq_e1", 32'(bus.hrq), 32'd0);
    tick();
    check("basic_hrq_e2", 32'(bus.hrq), 32'd1);
    tick();
    check("basic_nogrant", 32'(bus.validDack), 32'd0);
    bus.hlda = 1'b1;
    tick();
    check("basic_vdack", 32'(bus.validDack), 32'b0100);
    check("basic_dack",  32'(bus.dack),      32'b1011);
    check("basic_gch",   32'(bus.grantCh),   32'd2);
    bus.serviceDone = 1'b1;
    tick();
    bus.serviceDone = 1'b0;
    check("basic_rel_hrq",   32'(bus.hrq),       32'd0);
    check("basic_rel_vdack", 32'(bus.validDack), 32'd0);
    check("basic_rel_dack",  32'(bus.dack),      32'hF);
    check("basic_top",       32'(bus.topCh),     32'd0);
    tick();
    check("basic_rehrq", 32'(bus.hrq), 32'd1);

    // Withdraw before hlda: back to IDLE, no grant
    bus.hlda = 1'b0;
    dreq = 4'b0000;
    repeat (2) tick();
    check("wd_hrq",   32'(bus.hrq),        32'd0);
    check("wd_gv",    32'(bus.grantValid), 32'd0);
    tick();

    // Fixed priority: ch1 always beats ch3
    dreq     = 4'b1010;
    bus.hlda = 1'b1;
    for (int n = 0; n < 3; n++) begin
      wait_grant("fixed", 1);
      bus.serviceDone = 1'b1;
      tick();
      bus.serviceDone = 1'b0;
      check("fixed_top", 32'(bus.topCh), 32'd0);
    end
    drain();

    // Rotating priority: all channels requesting
    rotatingPriority = 1'b1;
    dreq             = 4'b1111;
    bus.hlda         = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_grant("rot", n % 4);
      bus.serviceDone = 1'b1;
      tick();
      bus.serviceDone = 1'b0;
      check("rot_top", 32'(bus.topCh), 32'((n + 1) % 4));
    end
    drain();

    // Abort by hlda drop during GRANT of ch2: topCh unchanged
    dreq     = 4'b0100;
    bus.hlda = 1'b1;
    wait_grant("abort", 2);
    bus.hlda = 1'b0;
    tick();
    check("abort_gv",  32'(bus.grantValid), 32'd0);
    check("abort_vd",  32'(bus.validDack),  32'd0);
    check("abort_top", 32'(bus.topCh),      32'd1);
    drain();

    // Rotation disabled: topCh forced to 0 on the next edge
    rotatingPriority = 1'b0;
    tick();
    check("rotoff_top", 32'(bus.topCh), 32'd0);

    // Fully masked hardware requests never raise hrq
    mask = 4'hF;
    dreq = 4'hF;
    repeat (4) tick();
    check("mask_hrq", 32'(bus.hrq), 32'd0);
    // Software request bypasses mask, one-edge latency
    softReq = 4'b1000;
    tick();
    check("soft_hrq", 32'(bus.hrq), 32'd1);
    bus.hlda = 1'b1;
    tick();
    check("soft_vdack", 32'(bus.validDack), 32'b1000);
    check("soft_ch",    32'(bus.grantCh),   32'd3);
    drain();
    mask = 4'h0;
    tick();

    // ctrlDisable while in REQ drops hrq, no grant
    dreq = 4'b0001;
    repeat (2) tick();
    check("dis_req_hrq", 32'(bus.hrq), 32'd1);
    ctrlDisable = 1'b1;
    bus.hlda    = 1'b1;
    tick();
    check("dis_hrq", 32'(bus.hrq),        32'd0);
    check("dis_gv",  32'(bus.grantValid), 32'd0);
    tick();
    check("dis_hold", 32'(bus.hrq), 32'd0);
    ctrlDisable = 1'b0;

    // Reset during GRANT, hlda still high
    wait_grant("rstg", 0);
    RESET = 1'b0;
    tick();
    check("rstg_hrq",   32'(bus.hrq),        32'd0);
    check("rstg_vdack", 32'(bus.validDack),  32'd0);
    check("rstg_gv",    32'(bus.grantValid), 32'd0);
    check("rstg_dack",  32'(bus.dack),       32'hF);
    RESET = 1'b1;
    drain();

    // Polarity: active-low DREQ, then active-high DACK
    dreqActiveLow = 1'b1;
    dreq          = 4'b1110;
    bus.hlda      = 1'b1;
    wait_grant("pol", 0);
    check("pol_dack_lo", 32'(bus.dack), 32'b1110);
    dackActiveHigh = 1'b1;
    #1;
    check("pol_dack_hi", 32'(bus.dack), 32'b0001);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
